// File: rtl/prog_mem_ctrl.sv
// rtl/prog_mem_ctrl.sv - program memory with clear sweep, burst loader and checksum
// Optional registered readback port enabled by PROG_MEM_READBACK_EN.
module prog_mem_ctrl #(
  parameter int A = 8,
  parameter int D = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [A-1:0] address,
  output logic [D-1:0] dbuso,
  input  logic         load_start,
  input  logic [A-1:0] load_base,
  input  logic [A:0]   load_len,
  input  logic         ld_valid,
  input  logic [D-1:0] ld_data,
  output logic         ld_ready,
  input  logic         load_abort,
  input  logic         clr_req,
  output logic         busy,
  output logic         load_done,
  output logic         load_err,
  output logic [D-1:0] checksum
`ifdef PROG_MEM_READBACK_EN
  ,
  input  logic [A-1:0] rb_addr,
  output logic [D-1:0] rb_data
`endif
);

  localparam int DEPTH = 1 << A;

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    LOAD,
    DONE
  } state_t;

  state_t       r_state;
  state_t       w_next;
  logic [D-1:0] r_mem [DEPTH];
  logic [A-1:0] r_sweep;
  logic [A-1:0] r_ptr;
  logic [A:0]   r_remaining;
  logic [D-1:0] r_checksum;
  logic         r_err;

  logic         w_accept;
  logic         w_start;
  logic         w_we;
  logic [A-1:0] w_waddr;
  logic [D-1:0] w_wdata;

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_start  = 1'b0;
    w_we     = 1'b0;
    w_waddr  = r_ptr;
    w_wdata  = ld_data;
    case (r_state)
      CLEAR: begin
        w_we    = 1'b1;
        w_waddr = r_sweep;
        w_wdata = '0;
        if (r_sweep == '1) w_next = IDLE;
      end
      IDLE: begin
        // Clear request has priority over a simultaneous load start.
        if (clr_req) begin
          w_next = CLEAR;
        end else if (load_start) begin
          w_start = 1'b1;
          w_next  = (load_len == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        w_accept = ld_valid;
        w_we     = ld_valid;
        if (load_abort) w_next = IDLE;
        else if (ld_valid && r_remaining == (A+1)'(1)) w_next = DONE;
      end
      DONE: w_next = IDLE;
      default: w_next = CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= CLEAR;
      r_sweep     <= '0;
      r_ptr       <= '0;
      r_remaining <= '0;
      r_checksum  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == CLEAR) r_sweep <= r_sweep + A'(1);
      else if (w_next == CLEAR) r_sweep <= '0;
      if (w_start) begin
        r_ptr       <= load_base;
        r_remaining <= load_len;
        r_checksum  <= '0;
        r_err       <= 1'b0;
      end
      if (w_accept) begin
        r_ptr       <= r_ptr + A'(1);
        r_remaining <= r_remaining - (A+1)'(1);
        r_checksum  <= r_checksum + ld_data;
      end
      if (r_state == LOAD && load_abort) r_err <= 1'b1;
    end
  end

  // Storage is not reset; the clear sweep initialises it after every reset.
  always_ff @(posedge clk) begin
    if (w_we && !rst) r_mem[w_waddr] <= w_wdata;
  end

  assign dbuso     = (r_state == CLEAR) ? '0 : r_mem[address];
  assign busy      = (r_state != IDLE);
  assign ld_ready  = (r_state == LOAD);
  assign load_done = (r_state == DONE);
  assign load_err  = r_err;
  assign checksum  = r_checksum;

`ifdef PROG_MEM_READBACK_EN
  logic [D-1:0] r_rb_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rb_data <= '0;
    else     r_rb_data <= r_mem[rb_addr];
  end

  assign rb_data = r_rb_data;
`endif

endmodule

// File: tb/tb_prog_mem_ctrl.sv
// tb/tb_prog_mem_ctrl.sv - scoreboard bench for prog_mem_ctrl
module tb_prog_mem_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] address;
  logic [7:0] dbuso;
  logic       load_start;
  logic [7:0] load_base;
  logic [8:0] load_len;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_ready;
  logic       load_abort;
  logic       clr_req;
  logic       busy;
  logic       load_done;
  logic       load_err;
  logic [7:0] checksum;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] model [256];
  logic [7:0] wd [8];
  logic [7:0] exp_q [$];

  prog_mem_ctrl #(.A(8), .D(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .address    (address),
    .dbuso      (dbuso),
    .load_start (load_start),
    .load_base  (load_base),
    .load_len   (load_len),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .load_abort (load_abort),
    .clr_req    (clr_req),
    .busy       (busy),
    .load_done  (load_done),
    .load_err   (load_err),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  task automatic check_mem(input logic [7:0] lo, input int n, input string name);
    logic [7:0] a;
    logic [7:0] e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      a = lo + 8'(i);
      exp_q.push_back(model[a]);
      address = a;
      #1;
      e = exp_q.pop_front();
      n_checks++;
      if (dbuso !== e) begin
        n_errors++;
        $display("FAIL %s mem[%02h]: got %02h expected %02h", name, a, dbuso, e);
      end
    end
  endtask

  task automatic wait_sweep(input string name);
    int cnt = 0;
    int bad = 0;
    while (busy === 1'b1 && cnt < 1000) begin
      address = 8'(cnt * 37);
      #1;
      if (dbuso !== 8'h00) bad++;
      cnt++;
      @(negedge clk);
    end
    n_checks++;
    if (cnt != 256) begin
      n_errors++;
      $display("FAIL %s sweep_len: got %0d cycles expected 256", name, cnt);
    end
    n_checks++;
    if (bad != 0) begin
      n_errors++;
      $display("FAIL %s dbuso_during_clear: got %0d nonzero reads expected 0", name, bad);
    end
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
  endtask

  task automatic run_burst(input logic [7:0] base, input logic [8:0] len, input int nw,
                           input int abort_after, input logic [7:0] exp_sum,
                           input int exp_done, input logic exp_err, input string name);
    logic [7:0] ptr = base;
    int idx = 0;
    int dones = 0;
    @(negedge clk);
    load_start = 1'b1;
    load_base  = base;
    load_len   = len;
    @(negedge clk);
    load_start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (load_done === 1'b1) dones++;
      load_abort = 1'b0;
      ld_valid   = 1'b0;
      if (ld_ready === 1'b1 && abort_after >= 0 && idx == abort_after) begin
        load_abort = 1'b1;
      end else if (ld_ready === 1'b1 && idx < nw) begin
        ld_valid   = 1'b1;
        ld_data    = wd[idx];
        model[ptr] = wd[idx];
        ptr        = ptr + 8'd1;
        idx++;
      end
      @(negedge clk);
    end
    load_abort = 1'b0;
    ld_valid   = 1'b0;
    n_checks++;
    if (dones != exp_done) begin
      n_errors++;
      $display("FAIL %s load_done_pulses: got %0d expected %0d", name, dones, exp_done);
    end
    n_checks++;
    if (checksum !== exp_sum) begin
      n_errors++;
      $display("FAIL %s checksum: got %02h expected %02h", name, checksum, exp_sum);
    end
    n_checks++;
    if (load_err !== exp_err) begin
      n_errors++;
      $display("FAIL %s load_err: got %b expected %b", name, load_err, exp_err);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL %s busy_after: got %b expected 0", name, busy);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
    rst = 1'b1;
    address = 8'h00; load_start = 1'b0; load_base = 8'h00; load_len = 9'd0;
    ld_valid = 1'b0; ld_data = 8'h00; load_abort = 1'b0; clr_req = 1'b0;
    #22;
    n_checks++;
    if (busy !== 1'b1 || ld_ready !== 1'b0 || load_done !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_ctrl: got busy=%b ld_ready=%b load_done=%b expected 1 0 0",
               busy, ld_ready, load_done);
    end
    n_checks++;
    if (checksum !== 8'h00 || load_err !== 1'b0 || dbuso !== 8'h00) begin
      n_errors++;
      $display("FAIL reset_regs: got checksum=%02h load_err=%b dbuso=%02h expected 00 0 00",
               checksum, load_err, dbuso);
    end
    @(negedge clk);
    rst = 1'b0;
    wait_sweep("reset");
    check_mem(8'h00, 256, "reset");
  endtask

  task automatic test_basic_load();
    wd[0] = 8'h11; wd[1] = 8'h22; wd[2] = 8'h33;
    run_burst(8'h10, 9'd3, 3, -1, 8'h66, 1, 1'b0, "basic");
    check_mem(8'h0F, 5, "basic");
  endtask

  task automatic test_wrap();
    wd[0] = 8'h01; wd[1] = 8'h02; wd[2] = 8'h03; wd[3] = 8'h04;
    run_burst(8'hFE, 9'd4, 4, -1, 8'h0A, 1, 1'b0, "wrap");
    check_mem(8'hFD, 6, "wrap");
  endtask

  task automatic test_zero_len();
    run_burst(8'h30, 9'd0, 0, -1, 8'h00, 1, 1'b0, "zero_len");
    check_mem(8'h2F, 3, "zero_len");
  endtask

  task automatic test_abort();
    wd[0] = 8'h05; wd[1] = 8'h07; wd[2] = 8'h09; wd[3] = 8'h0B; wd[4] = 8'h0D;
    run_burst(8'h40, 9'd5, 5, 2, 8'h0C, 0, 1'b1, "abort");
    check_mem(8'h40, 5, "abort");
  endtask

  task automatic test_clr_priority();
    @(negedge clk);
    clr_req    = 1'b1;
    load_start = 1'b1;
    load_base  = 8'h80;
    load_len   = 9'd2;
    @(negedge clk);
    clr_req    = 1'b0;
    load_start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || ld_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL clr_prio_enter: got busy=%b ld_ready=%b expected 1 0", busy, ld_ready);
    end
    wait_sweep("clr_prio");
    n_checks++;
    if (checksum !== 8'h0C || load_err !== 1'b1) begin
      n_errors++;
      $display("FAIL clr_prio_load_ignored: got checksum=%02h load_err=%b expected 0c 1",
               checksum, load_err);
    end
    check_mem(8'h00, 256, "clr_prio");
  endtask

  task automatic test_rst_mid_burst();
    @(negedge clk);
    load_start = 1'b1;
    load_base  = 8'h20;
    load_len   = 9'd4;
    @(negedge clk);
    load_start = 1'b0;
    ld_valid   = 1'b1;
    ld_data    = 8'h5A;
    @(negedge clk);
    ld_data    = 8'h6B;
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (ld_ready !== 1'b0 || busy !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_mid_ctrl: got ld_ready=%b busy=%b expected 0 1", ld_ready, busy);
    end
    n_checks++;
    if (checksum !== 8'h00 || load_err !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_mid_regs: got checksum=%02h load_err=%b expected 00 0", checksum, load_err);
    end
    ld_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    wait_sweep("rst_mid");
    check_mem(8'h00, 256, "rst_mid");
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_wrap();
    test_zero_len();
    test_abort();
    test_clr_priority();
    test_rst_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
